// File: rtl/sfu_buf_pkg.sv
// SFU output buffer shared helpers.
// Width functions, lane slicing and parameter legality.
package sfu_buf_pkg;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic bit params_ok(
    input int depth,
    input int af,
    input int ae
  );
    return (depth >= 2) && (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sfu_buf_ram.sv
// SFU output buffer storage.
// One write port (clocked), one asynchronous read port, no reset.
module sfu_buf_ram #(
  parameter int W     = 132,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfu_out_buffer.sv
// Multi-lane FWFT output buffer between SFU datapath and streamer.
// Arbitrary depth, level, almost flags, flush and sticky overflow.
module sfu_out_buffer
  import sfu_buf_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_keep,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_keep,
  output logic [lvl_w(DEPTH)-1:0]      level,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow
);

  localparam int LW = lvl_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int DW = NUM_CH * DATA_WIDTH;
  localparam int EW = DW + NUM_CH;

  if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sfu_out_buffer: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [EW-1:0] rd_word;

  assign in_ready     = (level_q != LW'(DEPTH));
  assign out_valid    = (level_q != '0);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign level        = level_q;
  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));
  assign overflow     = ovf_q;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) wr_d = nxt(wr_q);
      if (pop)  rd_d = nxt(rd_q);
      level_d = level_q + LW'(push) - LW'(pop);
      ovf_d   = ovf_q | (in_valid & ~in_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  sfu_buf_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_q),
    .wdata ({in_keep, in_data}),
    .raddr (rd_q),
    .rdata (rd_word)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, DATA_WIDTH);
    assign out_data[LSB +: DATA_WIDTH] =
      out_valid ? rd_word[LSB +: DATA_WIDTH] : '0;
  end

  assign out_keep = out_valid ? rd_word[EW-1 -: NUM_CH] : '0;

endmodule

// File: tb/tb_sfu_out_buffer.sv
// Directed self-checking bench for sfu_out_buffer.
// Main instance DEPTH=16, second instance DEPTH=5 for wrap.
module tb_sfu_out_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_keep;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic [4:0]   level;
  logic         almost_full;
  logic         almost_empty;
  logic         overflow;

  logic         f5_flush;
  logic         f5_in_valid;
  logic         f5_in_ready;
  logic [127:0] f5_in_data;
  logic [3:0]   f5_in_keep;
  logic         f5_out_valid;
  logic         f5_out_ready;
  logic [127:0] f5_out_data;
  logic [3:0]   f5_out_keep;
  logic [2:0]   f5_level;
  logic         f5_af;
  logic         f5_ae;
  logic         f5_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sfu_out_buffer #(
    .NUM_CH(4), .DATA_WIDTH(32), .DEPTH(16),
    .AF_THRESH(14), .AE_THRESH(1)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep),
    .level(level), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow)
  );

  sfu_out_buffer #(
    .NUM_CH(4), .DATA_WIDTH(32), .DEPTH(5),
    .AF_THRESH(3), .AE_THRESH(1)
  ) u_d5 (
    .clk(clk), .rst(rst), .flush(f5_flush),
    .in_valid(f5_in_valid), .in_ready(f5_in_ready),
    .in_data(f5_in_data), .in_keep(f5_in_keep),
    .out_valid(f5_out_valid), .out_ready(f5_out_ready),
    .out_data(f5_out_data), .out_keep(f5_out_keep),
    .level(f5_level), .almost_full(f5_af),
    .almost_empty(f5_ae), .overflow(f5_ovf)
  );

  function automatic logic [127:0] word(input int n);
    logic [31:0] b;
    b = 32'(n);
    return {32'hD000_0000 + b, 32'hC000_0000 + b,
            32'hB000_0000 + b, 32'hA000_0000 + b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d,
                       input logic [3:0] k, input logic r);
    in_valid  = v;
    in_data   = d;
    in_keep   = k;
    out_ready = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (out_keep !== 4'h0) begin bad++; $display("FAIL rst_out_keep got=%h exp=0", out_keep); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", almost_full); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", almost_empty); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    total++; if (f5_level !== 3'd0) begin bad++; $display("FAIL rst_d5_level got=%0d exp=0", f5_level); end
  endtask

  task automatic test_first_word();
    drive(1'b1, {4{32'h1111_1111}}, 4'hF, 1'b0);
    tick();
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fw_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== {4{32'h1111_1111}}) begin bad++; $display("FAIL fw_data got=%h exp=%h", out_data, {4{32'h1111_1111}}); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL fw_keep got=%h exp=f", out_keep); end
    total++; if (level !== 5'd1) begin bad++; $display("FAIL fw_level got=%0d exp=1", level); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL fw_ae got=%b exp=1", almost_empty); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (level !== 5'd0) begin bad++; $display("FAIL fw_pop_level got=%0d exp=0", level); end
  endtask

  task automatic test_wrap_d5();
    logic [127:0] qd[$];
    logic [3:0]   qk[$];
    int sent = 0;
    int got  = 0;
    int lvl  = 0;
    int cyc  = 0;
    bit p, o;
    while (got < 12 && cyc < 200) begin
      f5_in_valid  = (sent < 12);
      f5_in_data   = word(200 + sent);
      f5_in_keep   = 4'(sent);
      f5_out_ready = cyc[0];
      #1;
      total++; if (f5_level !== 3'(lvl)) begin bad++; $display("FAIL d5_level cyc=%0d got=%0d exp=%0d", cyc, f5_level, lvl); end
      total++; if (f5_level > 3'd5) begin bad++; $display("FAIL d5_level_max got=%0d exp<=5", f5_level); end
      total++; if (f5_in_ready !== (lvl != 5)) begin bad++; $display("FAIL d5_in_ready got=%b exp=%b", f5_in_ready, lvl != 5); end
      if (lvl != 0) begin
        total++; if (f5_out_data !== qd[0]) begin bad++; $display("FAIL d5_data cyc=%0d got=%h exp=%h", cyc, f5_out_data, qd[0]); end
        total++; if (f5_out_keep !== qk[0]) begin bad++; $display("FAIL d5_keep got=%h exp=%h", f5_out_keep, qk[0]); end
      end
      p = f5_in_valid && (lvl != 5);
      o = f5_out_ready && (lvl != 0);
      if (p) begin
        qd.push_back(f5_in_data);
        qk.push_back(f5_in_keep);
        sent++;
      end
      if (o) begin
        void'(qd.pop_front());
        void'(qk.pop_front());
        got++;
      end
      lvl = lvl + int'(p) - int'(o);
      cyc++;
      tick();
    end
    f5_in_valid  = 1'b0;
    f5_out_ready = 1'b0;
    total++; if (got != 12) begin bad++; $display("FAIL d5_timeout got=%0d exp=12", got); end
    total++; if (f5_out_valid !== 1'b0) begin bad++; $display("FAIL d5_empty got=%b exp=0", f5_out_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, word(i), 4'hF, 1'b0);
      #1;
      total++; if (almost_full !== (i >= 14)) begin bad++; $display("FAIL full_af lvl=%0d got=%b exp=%b", i, almost_full, i >= 14); end
      tick();
    end
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL full_af16 got=%b exp=1", almost_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_pre got=%b exp=0", overflow); end
    drive(1'b1, word(99), 4'hF, 1'b1);
    #1;
    total++; if (out_data !== word(0)) begin bad++; $display("FAIL full_head got=%h exp=%h", out_data, word(0)); end
    tick();
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (level !== 5'd15) begin bad++; $display("FAIL full_level15 got=%0d exp=15", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", overflow); end
    total++; if (out_data !== word(1)) begin bad++; $display("FAIL full_head1 got=%h exp=%h", out_data, word(1)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready15 got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    repeat (7) tick();
    out_ready = 1'b0;
    total++; if (level !== 5'd8) begin bad++; $display("FAIL b2b_level_pre got=%0d exp=8", level); end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, word(16 + k), 4'hF, 1'b1);
      #1;
      total++; if (level !== 5'd8) begin bad++; $display("FAIL b2b_level k=%0d got=%0d exp=8", k, level); end
      total++; if (out_data !== word(8 + k)) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, out_data, word(8 + k)); end
      tick();
    end
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (level !== 5'd8) begin bad++; $display("FAIL b2b_level_post got=%0d exp=8", level); end
    total++; if (out_data !== word(28)) begin bad++; $display("FAIL b2b_head got=%h exp=%h", out_data, word(28)); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    total++; if (level !== 5'd6) begin bad++; $display("FAIL fl_level_pre got=%0d exp=6", level); end
    total++; if (out_data !== word(30)) begin bad++; $display("FAIL fl_head got=%h exp=%h", out_data, word(30)); end
    drive(1'b1, word(77), 4'hF, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (level !== 5'd0) begin bad++; $display("FAIL fl_level got=%0d exp=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL fl_data got=%h exp=0", out_data); end
    total++; if (out_keep !== 4'h0) begin bad++; $display("FAIL fl_keep got=%h exp=0", out_keep); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fl_ovf got=%b exp=0", overflow); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL fl_ae got=%b exp=1", almost_empty); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, word(50 + i), 4'hF, 1'b0);
      tick();
    end
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (level !== 5'd3) begin bad++; $display("FAIL mr_level_pre got=%0d exp=3", level); end
    total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL mr_ae3 got=%b exp=0", almost_empty); end
    drive(1'b1, word(53), 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (level !== 5'd0) begin bad++; $display("FAIL mr_level got=%0d exp=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL mr_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mr_in_ready got=%b exp=1", in_ready); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL mr_ae got=%b exp=1", almost_empty); end
    drive(1'b1, word(60), 4'b0101, 1'b0);
    tick();
    drive(1'b0, '0, 4'h0, 1'b0);
    total++; if (out_keep !== 4'b0101) begin bad++; $display("FAIL mr_keep got=%b exp=0101", out_keep); end
    total++; if (out_data !== word(60)) begin bad++; $display("FAIL mr_data2 got=%h exp=%h", out_data, word(60)); end
    total++; if (level !== 5'd1) begin bad++; $display("FAIL mr_level2 got=%0d exp=1", level); end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_keep      = '0;
    out_ready    = 1'b0;
    f5_flush     = 1'b0;
    f5_in_valid  = 1'b0;
    f5_in_data   = '0;
    f5_in_keep   = '0;
    f5_out_ready = 1'b0;
    #1;
    test_reset();
    test_first_word();
    test_wrap_d5();
    test_full();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfu_out_buffer.md
Name: sfu_out_buffer

Overview:
Parametrised successor to the SFU output FIFO: a multi-lane, ready/valid output buffer between the SFU datapath and the streamer write port. Stores NUM_CH lanes of DATA_WIDTH per entry plus a per-lane keep mask, at arbitrary (non-power-of-two) depth. Adds first-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag.

Parameters:
NUM_CH, 4, lanes per entry
DATA_WIDTH, 32, bits per lane
DEPTH, 16, entries; any integer >= 2
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents and flags
in_valid  in  1  producer has a word
in_ready  out  1  buffer can accept a word
in_data  in  NUM_CH*DATA_WIDTH  lane-packed word; lane 0 in LSBs
in_keep  in  NUM_CH  per-lane valid mask, stored with the data
out_valid  out  1  head entry available
out_ready  in  1  consumer takes head
out_data  out  NUM_CH*DATA_WIDTH  head data
out_keep  out  NUM_CH  head keep mask
level  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
overflow  out  1  sticky: push attempted while in_ready=0

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge): wr_ptr=rd_ptr=0, level=0, overflow=0. After reset: in_ready=1, out_valid=0, out_data=0, out_keep=0, almost_full=0 (AF_THRESH>=1), almost_empty=1. Storage is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level != DEPTH); derived only from registered state, with no combinational path from out_ready. Push while full is refused even if a pop occurs in the same cycle.
- out_valid = (level != 0). FWFT: out_data/out_keep = storage[rd_ptr] combinationally. When out_valid=0, out_data and out_keep are driven to 0.
- Latency: a word pushed at edge N is visible at out_valid/out_data after edge N (next cycle), including when empty.
- Pointers wrap explicitly: ptr == DEPTH-1 -> 0, so DEPTH need not be a power of two.
- level next = level + push - pop. Simultaneous push and pop leave level unchanged, and both pointers advance.
- almost_full and almost_empty are combinational compares on the level register.
- overflow is set on any edge with in_valid=1 and in_ready=0. It stays set until rst or flush.
- flush has priority over push and pop in the same cycle: pointers, level and overflow clear, and the in-flight push/pop is discarded. rst has priority over flush.
- Reset or flush mid-stream: all contents are lost. There is no partial drain.
- Pop on empty (out_ready=1, out_valid=0): no-op, not an error.

Decomposition:
- Package sfu_buf_pkg: function for the level width ($clog2(DEPTH+1)), lane-slice helper, and the parameter legality check (elaboration-time assertion on DEPTH, AF_THRESH, AE_THRESH).
- Sub-module sfu_buf_ram: 1-write/1-read storage, DEPTH x (NUM_CH*(DATA_WIDTH)+NUM_CH), synchronous write, asynchronous read, no reset.
- Pointer, level and flag logic stay in the top.

Test Plan:
- Reset, then push 0x1111_1111 x4 lanes with keep=4'b1111 -> next cycle out_valid=1, out_data=that word, level=1, almost_empty=1.
- DEPTH=5 (non-power-of-two): push 12 words with out_ready toggling every cycle -> words emerge in order, pointer wrap is exercised, level never exceeds 5.
- Fill to DEPTH=16 -> in_ready=0, almost_full=1 at level 14. Hold in_valid=1 with out_ready=1 for one cycle -> pop accepted, push refused, overflow=1, level=15.
- Level=8, push and pop in the same cycle for 20 cycles -> level stays 8 and data order is preserved.
- Level=6, flush=1 with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, out_data=0, overflow=0.
- Level=3, assert rst with in_valid=1 -> next cycle level=0 and all outputs at reset values. A subsequent push of keep=4'b0101 -> out_keep=4'b0101.
